// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alarm_pkg
// Description : Shared channel FSM encodings and event field definitions.
// Revision    : 1.0 - initial release
// ============================================================================
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMING    = 2'd1,
        ST_ACTIVE    = 2'd2,
        ST_DISARMING = 2'd3
    } chan_state_t;

    localparam int c_num_chan     = 3;
    localparam int c_evt_w        = 3;
    localparam int c_evt_kind_bit = 2;
    localparam int c_evt_chan_msb = 1;
    localparam int c_evt_chan_lsb = 0;

    localparam logic c_evt_raise = 1'b1;
    localparam logic c_evt_clear = 1'b0;

    localparam logic [1:0] c_chan1 = 2'd1;
    localparam logic [1:0] c_chan2 = 2'd2;
    localparam logic [1:0] c_chan3 = 2'd3;

    function automatic logic [c_evt_w-1:0] make_evt(input logic kind, input logic [1:0] chan);
        logic [c_evt_w-1:0] v;
        v = '0;
        v[c_evt_kind_bit] = kind;
        v[c_evt_chan_msb:c_evt_chan_lsb] = chan;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alarm_event_fifo
// Description : Power-of-two event queue; push while full is accepted only
//               together with a pop.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_event_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int               c_ptr_w = $clog2(FIFO_DEPTH);
    localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(FIFO_DEPTH);

    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign pop_data  = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/alarm_monitor.sv
`default_nettype none
// ============================================================================
// Module      : alarm_monitor
// Description : Debounces three buzzer levels into raise/clear events and
//               queues them for a ready/valid consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_monitor
    import alarm_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       buzzer1,
    input  logic       buzzer2,
    input  logic       buzzer3,
    output logic       evt_valid,
    output logic [2:0] evt_data,
    input  logic       evt_ready,
    output logic [2:0] active_mask,
    output logic       overflow
);

    localparam logic [3:0] c_hold = 4'(HOLD_CYCLES);
    localparam int         c_cnt_w = $clog2(FIFO_DEPTH) + 1;

    logic [c_num_chan-1:0] w_buzz;
    logic [c_num_chan-1:0] w_pend;
    logic [c_num_chan-1:0] w_pend_kind;
    logic [c_num_chan-1:0] w_drop;
    logic [c_num_chan-1:0] w_grant;
    logic [c_num_chan-1:0] w_active;
    logic [c_evt_w-1:0]    w_push_data;
    logic [c_evt_w-1:0]    w_pop_data;
    logic [c_cnt_w-1:0]    w_fifo_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_can_push;
    logic                  r_overflow;

    assign w_buzz = {buzzer3, buzzer2, buzzer1};

    for (genvar gi = 0; gi < c_num_chan; gi++) begin : g_chan
        chan_state_t r_state;
        logic [3:0]  r_cnt;
        logic        r_active;
        logic        r_pend;
        logic        r_pend_kind;
        logic        w_b;
        logic        w_hit;
        logic        w_gen;

        assign w_b   = w_buzz[gi];
        assign w_hit = ((r_cnt + 4'd1) == c_hold);
        assign w_gen = w_hit && (((r_state == ST_ARMING) && w_b) ||
                                 ((r_state == ST_DISARMING) && !w_b));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_state  <= ST_IDLE;
                r_cnt    <= '0;
                r_active <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_b) begin
                            r_state <= ST_ARMING;
                            r_cnt   <= 4'd1;
                        end
                    end
                    ST_ARMING: begin
                        if (!w_b) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end else if (w_hit) begin
                            r_state  <= ST_ACTIVE;
                            r_cnt    <= '0;
                            r_active <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (!w_b) begin
                            r_state <= ST_DISARMING;
                            r_cnt   <= 4'd1;
                        end
                    end
                    ST_DISARMING: begin
                        if (w_b) begin
                            r_state <= ST_ACTIVE;
                            r_cnt   <= '0;
                        end else if (w_hit) begin
                            r_state  <= ST_IDLE;
                            r_cnt    <= '0;
                            r_active <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_cnt    <= '0;
                        r_active <= 1'b0;
                    end
                endcase
            end
        end

        // A new event finding the slot still occupied is dropped; the older one wins.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_pend      <= 1'b0;
                r_pend_kind <= 1'b0;
            end else if (w_gen && !r_pend) begin
                r_pend      <= 1'b1;
                r_pend_kind <= (r_state == ST_ARMING) ? c_evt_raise : c_evt_clear;
            end else if (w_grant[gi]) begin
                r_pend <= 1'b0;
            end
        end

        assign w_pend[gi]      = r_pend;
        assign w_pend_kind[gi] = r_pend_kind;
        assign w_drop[gi]      = w_gen && r_pend;
        assign w_active[gi]    = r_active;
    end

    assign w_pop      = evt_ready && !w_empty;
    assign w_can_push = !w_full || w_pop;

    always_comb begin
        w_grant     = '0;
        w_push_data = '0;
        if (w_can_push) begin
            if (w_pend[0]) begin
                w_grant     = 3'b001;
                w_push_data = make_evt(w_pend_kind[0], c_chan1);
            end else if (w_pend[1]) begin
                w_grant     = 3'b010;
                w_push_data = make_evt(w_pend_kind[1], c_chan2);
            end else if (w_pend[2]) begin
                w_grant     = 3'b100;
                w_push_data = make_evt(w_pend_kind[2], c_chan3);
            end
        end
    end

    assign w_push = |w_grant;

    alarm_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (c_evt_w)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .pop_data  (w_pop_data),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         r_overflow <= 1'b0;
        else if (|w_drop)   r_overflow <= 1'b1;
    end

    assign evt_valid   = (w_fifo_count != '0);
    assign evt_data    = w_pop_data;
    assign active_mask = w_active;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_alarm_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_monitor
// Description : Directed and randomized checks of alarm_monitor against a
//               qualified-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_monitor;

    localparam int HOLD  = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       buzzer1 = 1'b0, buzzer2 = 1'b0, buzzer3 = 1'b0;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [2:0] evt_data;
    logic [2:0] active_mask;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    // Model: a channel's qualified level flips after HOLD consecutive samples disagree with it.
    logic [2:0] m_lvl;
    int         m_streak [3];
    bit         m_pv [3];
    logic [2:0] m_pd [3];
    logic [2:0] m_q [$];
    logic       m_ovf;
    logic [2:0] obs [$];

    alarm_monitor #(.HOLD_CYCLES(HOLD), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .buzzer1     (buzzer1),
        .buzzer2     (buzzer2),
        .buzzer3     (buzzer3),
        .evt_valid   (evt_valid),
        .evt_data    (evt_data),
        .evt_ready   (evt_ready),
        .active_mask (active_mask),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lvl = '0;
        m_ovf = 1'b0;
        m_q.delete();
        for (int k = 0; k < 3; k++) begin
            m_streak[k] = 0;
            m_pv[k]     = 1'b0;
            m_pd[k]     = '0;
        end
    endtask

    task automatic model_edge(input logic [2:0] b, input logic rdy);
        bit         do_pop;
        int         pch;
        bit         old_pv [3];
        bit         gen [3];
        logic [2:0] gd [3];
        do_pop = (m_q.size() > 0) && rdy;
        pch = -1;
        if (m_q.size() < DEPTH || do_pop)
            for (int k = 0; k < 3; k++)
                if (m_pv[k] && pch < 0) pch = k;
        for (int k = 0; k < 3; k++) begin
            old_pv[k] = m_pv[k];
            gen[k]    = 1'b0;
            gd[k]     = '0;
            if (b[k] != m_lvl[k]) begin
                m_streak[k]++;
                if (m_streak[k] == HOLD) begin
                    m_lvl[k]    = ~m_lvl[k];
                    m_streak[k] = 0;
                    gen[k]      = 1'b1;
                    gd[k]       = {m_lvl[k], 2'(k + 1)};
                end
            end else begin
                m_streak[k] = 0;
            end
        end
        if (do_pop) void'(m_q.pop_front());
        if (pch >= 0) begin
            m_q.push_back(m_pd[pch]);
            m_pv[pch] = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            if (gen[k]) begin
                if (old_pv[k]) m_ovf = 1'b1;
                else begin
                    m_pv[k] = 1'b1;
                    m_pd[k] = gd[k];
                end
            end
        end
    endtask

    task automatic compare(input string tag);
        logic [2:0] exp_data;
        exp_data = (m_q.size() > 0) ? m_q[0] : 3'b000;
        check({tag, "_valid"}, 8'(evt_valid), 8'(m_q.size() > 0));
        check({tag, "_data"}, 8'(evt_data), 8'(exp_data));
        check({tag, "_mask"}, 8'(active_mask), 8'(m_lvl));
        check({tag, "_ovf"}, 8'(overflow), 8'(m_ovf));
    endtask

    // Called at a falling edge: drive, let one rising edge happen, then compare.
    task automatic step(input logic [2:0] b, input logic rdy);
        {buzzer3, buzzer2, buzzer1} = b;
        evt_ready = rdy;
        if (evt_valid && rdy) obs.push_back(evt_data);
        @(posedge clk);
        model_edge(b, rdy);
        @(negedge clk);
        compare("cyc");
    endtask

    task automatic steps(input int n, input logic [2:0] b, input logic rdy);
        for (int i = 0; i < n; i++) step(b, rdy);
    endtask

    // Asserted between clock edges so the clear must be asynchronous.
    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_valid", 8'(evt_valid), 8'd0);
        check("rst_mask", 8'(active_mask), 8'd0);
        check("rst_ovf", 8'(overflow), 8'd0);
        check("rst_data", 8'(evt_data), 8'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [2:0] exp4 [4];
        logic [2:0] b;
        logic       rdy;

        model_reset();
        @(negedge clk);
        compare("reset");
        @(negedge clk);
        reset = 1'b1;

        // Single qualified raise on channel 1
        steps(4, 3'b001, 1'b1);
        check("s1_mask", 8'(active_mask), 8'h1);
        check("s1_valid_early", 8'(evt_valid), 8'd0);
        step(3'b001, 1'b1);
        check("s1_data", 8'(evt_data), 8'h5);
        steps(8, 3'b000, 1'b1);

        // Too-short pulse on channel 2
        do_reset();
        steps(3, 3'b010, 1'b1);
        steps(6, 3'b000, 1'b1);
        check("s2_mask", 8'(active_mask), 8'd0);
        check("s2_valid", 8'(evt_valid), 8'd0);

        // Simultaneous raise on channels 2 and 3, then clear
        do_reset();
        obs.delete();
        steps(10, 3'b110, 1'b1);
        steps(4, 3'b000, 1'b1);
        steps(6, 3'b000, 1'b1);
        exp4 = '{3'b110, 3'b111, 3'b010, 3'b011};
        check("s3_count", 8'(obs.size()), 8'd4);
        for (int i = 0; i < 4; i++)
            check("s3_order", 8'((i < obs.size()) ? obs[i] : 3'bxxx), 8'(exp4[i]));

        // Short dropout while active yields no clear
        do_reset();
        obs.delete();
        steps(4, 3'b001, 1'b1);
        steps(3, 3'b000, 1'b1);
        steps(3, 3'b001, 1'b1);
        check("s4_mask", 8'(active_mask), 8'h1);
        steps(2, 3'b001, 1'b1);
        check("s4_events", 8'(obs.size()), 8'd1);

        // Back-pressure: fill the queue, overflow, then drain in order
        do_reset();
        obs.delete();
        for (int r = 0; r < 3; r++) begin
            steps(4, 3'b001, 1'b0);
            steps(4, 3'b000, 1'b0);
        end
        check("s5_ovf", 8'(overflow), 8'h1);
        steps(8, 3'b000, 1'b1);
        exp4 = '{3'b101, 3'b001, 3'b101, 3'b001};
        check("s5_drained", 8'(obs.size() >= 4), 8'd1);
        for (int i = 0; i < 4; i++)
            check("s5_order", 8'((i < obs.size()) ? obs[i] : 3'bxxx), 8'(exp4[i]));
        check("s5_ovf_sticky", 8'(overflow), 8'h1);

        // Reset mid-arming with two queued events and overflow set
        steps(4, 3'b011, 1'b0);
        steps(3, 3'b111, 1'b0);
        check("s6_pre_valid", 8'(evt_valid), 8'h1);
        do_reset();

        // Randomized run with periodic back-pressure stretches and resets
        b = 3'b000;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 3; k++)
                if ($urandom_range(0, 4) == 0) b[k] = ~b[k];
            rdy = ((c % 200) < 60) ? 1'b0 : ($urandom_range(0, 3) != 0);
            step(b, rdy);
            if (c == 700 || c == 1100) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
